// File: rtl/data_ram_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   dr_state_t            - responder state encoding (DR_INIT, DR_RUN)
//   DR_ADDR_WIDTH_DEFAULT - default word-index width (256 words)
//   DM_LANES / DM_LANE_W  - byte-lane organisation of a data word
package data_ram_pkg;

    typedef enum logic {
        DR_INIT = 1'b0,
        DR_RUN  = 1'b1
    } dr_state_t;

    localparam int DR_ADDR_WIDTH_DEFAULT = 8;
    localparam int DM_LANES              = 4;
    localparam int DM_LANE_W             = 8;

endpackage : data_ram_pkg

// File: rtl/dm_byte_bank.sv
// One byte lane of the data RAM: 8 bits wide, 2**ADDR_WIDTH deep.
// Synchronous read-first port: the registered read returns the contents
// before any write performed on the same edge.
// Optional macro DATA_RAM_DEBUG_PORT_EN adds an asynchronous inspection read.
// Ports:
//   clk           rising-edge clock
//   i_we          lane write enable
//   i_addr        word index
//   i_wdata       lane write data
//   o_rdata       registered lane read data
//   i_test_addr   (debug) inspection word index
//   o_test_data   (debug) combinational inspection data
module dm_byte_bank
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DR_ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DM_LANE_W-1:0]  i_wdata,
`ifdef DATA_RAM_DEBUG_PORT_EN
    input  logic [ADDR_WIDTH-1:0] i_test_addr,
    output logic [DM_LANE_W-1:0]  o_test_data,
`endif
    output logic [DM_LANE_W-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DM_LANE_W-1:0] r_mem [0:DEPTH-1];
    logic [DM_LANE_W-1:0] r_rdata;

    // No reset on the array or read register so the lane maps onto block RAM;
    // the owner gates the read data while it is not meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

`ifdef DATA_RAM_DEBUG_PORT_EN
    assign o_test_data = r_mem[i_test_addr];
`endif

endmodule : dm_byte_bank

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-organised RAM with per-byte write enables and
// a fixed one-cycle read latency. After reset a sweep writes INIT_VALUE to
// every word (INIT) before requester accesses are honoured (RUN).
// Optional macro DATA_RAM_DEBUG_PORT_EN adds test_addr/test_data for
// asynchronous memory inspection.
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   dm_addr    byte address; word index = dm_addr[ADDR_WIDTH+1:2]
//   dm_wen     byte-lane write enables
//   dm_wdata   lane-aligned write data
//   dm_rdata   read data for the address presented in the previous cycle
//   dm_ready   high once initialisation is complete
//   test_addr  (debug) inspection byte address
//   test_data  (debug) combinational inspection data, 0 while not ready
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH = DR_ADDR_WIDTH_DEFAULT,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
`ifdef DATA_RAM_DEBUG_PORT_EN
    input  logic [31:0] test_addr,
    output logic [31:0] test_data,
`endif
    output logic [31:0] dm_rdata,
    output logic        dm_ready
);

    dr_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic                  r_ready;
    logic                  r_rd_ok;

    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic [ADDR_WIDTH-1:0] w_bank_addr;
    logic                  w_in_init;
    logic [DM_LANES-1:0]   w_bank_we;
    logic [31:0]           w_bank_wdata;
    logic [31:0]           w_bank_q;

    // Address bits outside the word index alias and are deliberately dropped.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, dm_addr[31:ADDR_WIDTH+2], dm_addr[1:0]};

    assign w_req_idx   = dm_addr[ADDR_WIDTH+1:2];
    assign w_in_init   = (r_state == DR_INIT);
    assign w_bank_addr = w_in_init ? r_init_ptr : w_req_idx;

    // Single FSM: INIT sweeps every index once, then RUN is held until reset.
    // r_rd_ok marks that the read captured on the previous edge was a RUN
    // read, so the edge that leaves INIT still yields zero read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= DR_INIT;
            r_init_ptr <= '0;
            r_ready    <= 1'b0;
            r_rd_ok    <= 1'b0;
        end else begin
            r_rd_ok <= (r_state == DR_RUN);
            case (r_state)
                DR_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (&r_init_ptr) begin
                        r_state <= DR_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DR_RUN;
                end
            endcase
        end
    end

`ifdef DATA_RAM_DEBUG_PORT_EN
    logic [31:0] w_test_q;
    logic        w_unused_test_bits;
    assign w_unused_test_bits = &{1'b0, test_addr[31:ADDR_WIDTH+2], test_addr[1:0]};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DM_LANES; gi++) begin : g_lane
            // During INIT every lane is forced to write the init pattern.
            assign w_bank_we[gi] = w_in_init | dm_wen[gi];
            assign w_bank_wdata[gi*DM_LANE_W +: DM_LANE_W] = w_in_init
                ? INIT_VALUE[gi*DM_LANE_W +: DM_LANE_W]
                : dm_wdata[gi*DM_LANE_W +: DM_LANE_W];

            dm_byte_bank #(
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_bank (
                .clk         (clk),
                .i_we        (w_bank_we[gi]),
                .i_addr      (w_bank_addr),
                .i_wdata     (w_bank_wdata[gi*DM_LANE_W +: DM_LANE_W]),
`ifdef DATA_RAM_DEBUG_PORT_EN
                .i_test_addr (test_addr[ADDR_WIDTH+1:2]),
                .o_test_data (w_test_q[gi*DM_LANE_W +: DM_LANE_W]),
`endif
                .o_rdata     (w_bank_q[gi*DM_LANE_W +: DM_LANE_W])
            );
        end
    endgenerate

    assign dm_rdata = r_rd_ok ? w_bank_q : 32'h0;
    assign dm_ready = r_ready;

`ifdef DATA_RAM_DEBUG_PORT_EN
    assign test_data = r_ready ? w_test_q : 32'h0;
`endif

endmodule : data_ram_responder

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
`ifdef DATA_RAM_DEBUG_PORT_EN
    logic [31:0] test_addr;
    logic [31:0] test_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_ram_responder dut (
        .clk      (clk),
        .resetn   (resetn),
        .dm_addr  (dm_addr),
        .dm_wen   (dm_wen),
        .dm_wdata (dm_wdata),
`ifdef DATA_RAM_DEBUG_PORT_EN
        .test_addr(test_addr),
        .test_data(test_data),
`endif
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready)
    );

    // Reference model: a flat 1 KiB byte array; byte addresses wrap at 1 KiB.
    logic [7:0] mbytes [0:1023];

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
        end else begin
            $display("ok   %s value=%08h", nm, act);
        end
    endfunction

    function automatic void model_fill(input logic [31:0] v);
        for (int b = 0; b < 1024; b++) mbytes[b] = v[(b % 4)*8 +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int base;
        base = int'(a & 32'h3FC);
        return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        int base;
        base = int'(a & 32'h3FC);
        for (int k = 0; k < 4; k++) if (w[k]) mbytes[base+k] = d[k*8 +: 8];
    endfunction

    // Monitor: each access's read data appears just after the following edge.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, dm_rdata, e.exp);
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          input string nm, input bit use_c, input logic [31:0] c);
        sb_t e;
        @(negedge clk);
        dm_addr  = a;
        dm_wen   = w;
        dm_wdata = d;
        e.exp  = use_c ? c : model_read(a);
        e.name = nm;
        sb_q.push_back(e);
        model_write(a, w, d);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        dm_wen = 4'b0000;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb_q.size() > 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'h0);
            sb_q.delete();
        end
    endtask

    // Release reset at a falling edge and count rising edges until ready.
    task automatic release_and_wait(input string nm);
        int          n;
        logic [31:0] bad;
        bad = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (dm_ready) break;
            if (dm_rdata !== 32'h0 && bad == 32'h0) bad = dm_rdata;
        end
        check({nm, "_init_rdata_zero"}, bad, 32'h0);
        check({nm, "_ready_latency"}, 32'(n), 32'd256);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [3:0]  rw;
        resetn   = 1'b0;
        dm_addr  = 32'h8;
        dm_wen   = 4'b1111;
        dm_wdata = 32'hFFFF_FFFF;
`ifdef DATA_RAM_DEBUG_PORT_EN
        test_addr = 32'h0;
`endif
        model_fill(32'h0);
        #3;
        check("reset_ready", {31'h0, dm_ready}, 32'h0);
        check("reset_rdata", dm_rdata, 32'h0);
        repeat (3) @(posedge clk);

        // INIT sweep while the requester tries to write 0x8 (must be ignored).
        release_and_wait("init1");
        @(negedge clk);
        dm_wen = 4'b0000;

        access(32'h3C, 4'b0000, 32'h0, "read_0x3C_zero", 1'b1, 32'h0);
        access(32'h08, 4'b0000, 32'h0, "read_0x8_init_write_ignored", 1'b1, 32'h0);

        access(32'h10, 4'b1111, 32'hDEADBEEF, "write_0x10_full", 1'b0, 32'h0);
        access(32'h10, 4'b0000, 32'h0, "read_0x10", 1'b1, 32'hDEADBEEF);
        access(32'h10, 4'b0100, 32'h0055_0000, "write_0x10_lane2", 1'b0, 32'h0);
        access(32'h10, 4'b0000, 32'h0, "read_0x10_lane2", 1'b1, 32'hDE55BEEF);
        access(32'h10, 4'b0011, 32'h0000_1234, "write_0x10_lane10", 1'b0, 32'h0);
        access(32'h10, 4'b0000, 32'h0, "read_0x10_lane10", 1'b1, 32'hDE551234);

        access(32'h20, 4'b1111, 32'h1, "write_0x20_one", 1'b0, 32'h0);
        access(32'h20, 4'b1111, 32'h2, "rdw_0x20_old", 1'b1, 32'h1);
        access(32'h20, 4'b0000, 32'h0, "rdw_0x20_new", 1'b1, 32'h2);
        access(32'h420, 4'b0000, 32'h0, "alias_0x420", 1'b1, 32'h2);
        drain();

        // Randomized traffic against the byte-array model; full 32-bit
        // addresses exercise aliasing of the upper bits.
        for (int i = 0; i < 300; i++) begin
            ra = (i % 3 == 0) ? $urandom() : 32'($urandom_range(0, 32'h7F));
            rw = 4'($urandom_range(0, 15));
            rd = $urandom();
            access(ra, rw, rd, $sformatf("rand%0d", i), 1'b0, 32'h0);
        end
        drain();

        // Reset in the middle of RUN.
        access(32'h40, 4'b1111, 32'hA5A5A5A5, "write_0x40", 1'b0, 32'h0);
        access(32'h40, 4'b0000, 32'h0, "read_0x40_before_reset", 1'b1, 32'hA5A5A5A5);
        drain();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrun_reset_rdata", dm_rdata, 32'h0);
        check("midrun_reset_ready", {31'h0, dm_ready}, 32'h0);
        model_fill(32'h0);
        repeat (2) @(posedge clk);
        release_and_wait("init2");
        access(32'h40, 4'b0000, 32'h0, "read_0x40_after_reinit", 1'b1, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule : tb_data_ram_responder
